// File: rtl/adv_game_pkg.sv
// Shared types and constants for the adventure-game direction command front end.
package adv_game_pkg;

  localparam int unsigned NUM_DIRS = 4;
  localparam int unsigned DIR_N    = 0;
  localparam int unsigned DIR_S    = 1;
  localparam int unsigned DIR_E    = 2;
  localparam int unsigned DIR_W    = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PULSE  = 2'd1,
    GAP    = 2'd2,
    LOCKED = 2'd3
  } cmd_state_t;

  // Lower direction index wins: N > S > E > W.
  function automatic logic [NUM_DIRS-1:0] pick_dir(input logic [NUM_DIRS-1:0] req);
    logic [NUM_DIRS-1:0] onehot;
    onehot = '0;
    for (int i = NUM_DIRS - 1; i >= 0; i--) begin
      if (req[i]) onehot = NUM_DIRS'(1 << i);
    end
    return onehot;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One button: 2-flop synchronizer, stability-counter debounce, registered request strobe.
// With DIR_AUTOREPEAT_EN defined, a held button re-requests every REPEAT_CYCLES+1 cycles.
module btn_debounce #(
  parameter int unsigned DEB_CYCLES = 50000
`ifdef DIR_AUTOREPEAT_EN
  ,
  parameter int unsigned REPEAT_CYCLES = 25000000
`endif
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic req
);

  localparam int unsigned DW = $clog2(DEB_CYCLES + 1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          deb_q,   deb_d;
  logic [DW-1:0] cnt_q,   cnt_d;
  logic          req_q,   req_d;

`ifdef DIR_AUTOREPEAT_EN
  localparam int unsigned RW = $clog2(REPEAT_CYCLES + 1);
  logic [RW-1:0] hold_q, hold_d;
`endif

  always_comb begin
    sync1_d = btn;
    sync2_d = sync1_q;
    deb_d   = deb_q;
    cnt_d   = '0;
    // The counter only runs while the synced sample disagrees with the debounced level.
    if (sync2_q != deb_q) begin
      if (cnt_q == DW'(DEB_CYCLES - 1)) begin
        deb_d = ~deb_q;
      end else begin
        cnt_d = cnt_q + DW'(1);
      end
    end
    req_d = deb_d & ~deb_q;
`ifdef DIR_AUTOREPEAT_EN
    hold_d = '0;
    if (deb_q) begin
      if (hold_q == RW'(REPEAT_CYCLES)) begin
        req_d = 1'b1;
      end else begin
        hold_d = hold_q + RW'(1);
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      deb_q   <= 1'b0;
      cnt_q   <= '0;
      req_q   <= 1'b0;
`ifdef DIR_AUTOREPEAT_EN
      hold_q  <= '0;
`endif
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      deb_q   <= deb_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
`ifdef DIR_AUTOREPEAT_EN
      hold_q  <= hold_d;
`endif
    end
  end

  assign req = req_q;

endmodule

// File: rtl/dir_cmd_gen.sv
// Direction command generator: debounced buttons -> spaced one-hot n/s/e/w pulses, sword latch.
// Optional DIR_AUTOREPEAT_EN: held buttons periodically re-request their direction.
module dir_cmd_gen
  import adv_game_pkg::*;
#(
  parameter int unsigned DEB_CYCLES    = 50000,
  parameter int unsigned GAP_CYCLES    = 4,
  parameter int unsigned REPEAT_CYCLES = 25000000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_n,
  input  logic btn_s,
  input  logic btn_e,
  input  logic btn_w,
  input  logic sw,
  input  logic win,
  input  logic d,
  output logic n,
  output logic s,
  output logic e,
  output logic w,
  output logic v
);

  localparam int unsigned GW = $clog2(GAP_CYCLES + 1);

  if (DEB_CYCLES == 0 || GAP_CYCLES == 0 || REPEAT_CYCLES == 0) begin : g_bad_param
    $error("dir_cmd_gen: DEB_CYCLES, GAP_CYCLES and REPEAT_CYCLES must all be >= 1");
  end

  logic [NUM_DIRS-1:0] btn_raw;
  logic [NUM_DIRS-1:0] req_c;
  logic [NUM_DIRS-1:0] grant_c;
  logic                can_issue_c;

  cmd_state_t          state_q,   state_d;
  logic [NUM_DIRS-1:0] pending_q, pending_d;
  logic [NUM_DIRS-1:0] cmd_q,     cmd_d;
  logic [GW-1:0]       gap_q,     gap_d;
  logic                lock_q,    lock_d;
  logic                v_q,       v_d;

  assign btn_raw = {btn_w, btn_e, btn_s, btn_n};

  for (genvar g = 0; g < NUM_DIRS; g++) begin : g_btn
    btn_debounce #(
      .DEB_CYCLES   (DEB_CYCLES)
`ifdef DIR_AUTOREPEAT_EN
      ,
      .REPEAT_CYCLES(REPEAT_CYCLES)
`endif
    ) u_deb (
      .clk  (clk),
      .reset(reset),
      .btn  (btn_raw[g]),
      .req  (req_c[g])
    );
  end

  assign grant_c = pick_dir(pending_q);

  // Arbiter: a GAP whose counter has expired may grant directly, giving GAP_CYCLES+1 spacing.
  always_comb begin
    state_d     = state_q;
    pending_d   = pending_q | req_c;
    cmd_d       = '0;
    gap_d       = gap_q;
    lock_d      = lock_q | win | d;
    v_d         = v_q | sw;
    can_issue_c = 1'b0;

    case (state_q)
      IDLE:   can_issue_c = 1'b1;
      PULSE: begin
        state_d = GAP;
        gap_d   = GW'(GAP_CYCLES - 1);
      end
      GAP: begin
        if (gap_q == '0) can_issue_c = 1'b1;
        else             gap_d = gap_q - GW'(1);
      end
      LOCKED: pending_d = '0;
      default: state_d = IDLE;
    endcase

    if (can_issue_c) begin
      if (lock_q || win || d) begin
        state_d   = LOCKED;
        pending_d = '0;
      end else if (|pending_q) begin
        state_d   = PULSE;
        cmd_d     = grant_c;
        pending_d = (pending_q & ~grant_c) | req_c;
      end else begin
        state_d = IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      pending_q <= '0;
      cmd_q     <= '0;
      gap_q     <= '0;
      lock_q    <= 1'b0;
      v_q       <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      cmd_q     <= cmd_d;
      gap_q     <= gap_d;
      lock_q    <= lock_d;
      v_q       <= v_d;
    end
  end

  assign n = cmd_q[DIR_N];
  assign s = cmd_q[DIR_S];
  assign e = cmd_q[DIR_E];
  assign w = cmd_q[DIR_W];
  assign v = v_q;

endmodule

// File: tb/tb_dir_cmd_gen.sv
// Scoreboard bench for dir_cmd_gen with DEB_CYCLES=4, GAP_CYCLES=2, REPEAT_CYCLES=10.
module tb_dir_cmd_gen;
  import adv_game_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic btn_n = 1'b0, btn_s = 1'b0, btn_e = 1'b0, btn_w = 1'b0;
  logic sw = 1'b0, win = 1'b0, d = 1'b0;
  logic n, s, e, w, v;

  always #5 clk = ~clk;

  dir_cmd_gen #(
    .DEB_CYCLES   (4),
    .GAP_CYCLES   (2),
    .REPEAT_CYCLES(10)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .btn_n(btn_n),
    .btn_s(btn_s),
    .btn_e(btn_e),
    .btn_w(btn_w),
    .sw   (sw),
    .win  (win),
    .d    (d),
    .n    (n),
    .s    (s),
    .e    (e),
    .w    (w),
    .v    (v)
  );

  typedef struct {
    int dir;
    int at;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;
  int   seen  = 0;
  int   e0;

  logic [3:0] mon_o;
  exp_t       mon_ex;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every high output cycle must match the oldest expected pulse (direction and edge).
  always @(negedge clk) begin
    mon_o = {w, e, s, n};
    if (mon_o != 4'b0000) begin
      seen++;
      tests++;
      if (q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_pulse actual=%b at edge %0d required=none", mon_o, cyc);
      end else begin
        mon_ex = q.pop_front();
        if (mon_o != 4'(1 << mon_ex.dir) || cyc != mon_ex.at) begin
          fails++;
          $display("FAIL pulse actual=%b@%0d required=%b@%0d",
                   mon_o, cyc, 4'(1 << mon_ex.dir), mon_ex.at);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic expect_pulse(input int dir, input int at);
    exp_t x;
    x.dir = dir;
    x.at  = at;
    q.push_back(x);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    step(1);
    reset = 1'b1;
    step(2);
  endtask

  initial begin
    step(3);
    check("reset_outputs", 32'({n, s, e, w, v}), 32'h0);
    reset = 1'b1;
    step(2);

    // Single east press: pulse exactly on the cycle after edge e0+7.
    btn_e = 1'b1;
    e0 = cyc + 1;
    expect_pulse(int'(DIR_E), e0 + 7);
    step(10);
    btn_e = 1'b0;
    step(20);
    check("single_e_count", 32'(seen), 32'd1);

    // Bounce too short to debounce, then a real press.
    btn_n = 1'b1;
    step(3);
    btn_n = 1'b0;
    step(10);
    btn_n = 1'b1;
    e0 = cyc + 1;
    expect_pulse(int'(DIR_N), e0 + 7);
    step(6);
    btn_n = 1'b0;
    step(20);
    check("bounce_count", 32'(seen), 32'd2);

    // Simultaneous w, s, n: priority order, 3 cycles apart.
    btn_w = 1'b1;
    btn_s = 1'b1;
    btn_n = 1'b1;
    e0 = cyc + 1;
    expect_pulse(int'(DIR_N), e0 + 7);
    expect_pulse(int'(DIR_S), e0 + 10);
    expect_pulse(int'(DIR_W), e0 + 13);
    step(8);
    btn_w = 1'b0;
    btn_s = 1'b0;
    btn_n = 1'b0;
    step(25);
    check("simul_count", 32'(seen), 32'd5);

    // Sword latch survives sw dropping; reset clears it.
    sw = 1'b1;
    step(1);
    sw = 1'b0;
    check("v_set", 32'(v), 32'd1);
    step(3);
    check("v_held", 32'(v), 32'd1);
    reset = 1'b0;
    step(1);
    check("reset_clears_all", 32'({n, s, e, w, v}), 32'h0);
    reset = 1'b1;
    step(2);

    // Death arrives while s is pending: no s pulse, later presses ignored.
    btn_s = 1'b1;
    e0 = cyc + 1;
    step(7);
    d = 1'b1;
    step(1);
    d = 1'b0;
    step(5);
    btn_s = 1'b0;
    btn_n = 1'b1;
    step(8);
    btn_n = 1'b0;
    step(20);
    check("dead_no_pulse", 32'(seen), 32'd5);
    check("dead_v_clear", 32'(v), 32'd0);
    do_reset();

    // Win behaves the same.
    btn_s = 1'b1;
    step(7);
    win = 1'b1;
    step(1);
    win = 1'b0;
    step(5);
    btn_s = 1'b0;
    btn_e = 1'b1;
    step(8);
    btn_e = 1'b0;
    step(20);
    check("win_no_pulse", 32'(seen), 32'd5);
    do_reset();

    // Reset unlocks: a fresh west press is issued again.
    btn_w = 1'b1;
    e0 = cyc + 1;
    expect_pulse(int'(DIR_W), e0 + 7);
    step(8);
    btn_w = 1'b0;
    step(25);
    check("unlock_count", 32'(seen), 32'd6);

`ifdef DIR_AUTOREPEAT_EN
    // Held east: first pulse at +7, then every 11 cycles while the debounced level is high.
    btn_e = 1'b1;
    e0 = cyc + 1;
    expect_pulse(int'(DIR_E), e0 + 7);
    expect_pulse(int'(DIR_E), e0 + 18);
    expect_pulse(int'(DIR_E), e0 + 29);
    expect_pulse(int'(DIR_E), e0 + 40);
    step(40);
    btn_e = 1'b0;
    step(30);
    check("repeat_count", 32'(seen), 32'd10);
`endif

    check("queue_drained", 32'(q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
